// File: rtl/mont_pkg.sv
// mont_pkg: shared FSM state type and default widths for Montgomery precomputation
package mont_pkg;
    localparam int NBITS_DEF = 4096;
    localparam int WBITS_DEF = 64;
    typedef enum logic [1:0] {IDLE, RED1, RED2, FIN} state_t;
endpackage

// File: rtl/mont_ninv.sv
// mont_ninv: bit-serial -n^-1 mod 2^WBITS, one bit per cycle after start
module mont_ninv #(
    parameter int WBITS = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WBITS-1:0] n,
    output logic [WBITS-1:0] result,
    output logic             valid
);
    localparam int IW = $clog2(WBITS);
    logic [WBITS-1:0] n_r, y, t;
    logic [IW-1:0] i;
    logic run;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            n_r   <= '0;
            y     <= '0;
            t     <= '0;
            i     <= '0;
            run   <= 1'b0;
            valid <= 1'b0;
        end else if (start) begin
            n_r   <= n;
            y     <= WBITS'(1);
            t     <= n;
            i     <= IW'(1);
            run   <= 1'b1;
            valid <= 1'b0;
        end else if (run) begin
            if (t[i]) begin
                y[i] <= 1'b1;
                t    <= t + (n_r << i);
            end
            if (i == IW'(WBITS - 1)) begin
                run   <= 1'b0;
                valid <= 1'b1;
            end
            i <= i + IW'(1);
        end
    end
    assign result = ~y + WBITS'(1);
endmodule

// File: rtl/mont_precomp.sv
// mont_precomp: R mod n, R^2 mod n and -n^-1 mod 2^WBITS by shift-and-subtract reduction
module mont_precomp import mont_pkg::*; #(
    parameter int NBITS = NBITS_DEF,
    parameter int WBITS = WBITS_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go,
    input  logic             mode,
    input  logic [NBITS-1:0] n,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [NBITS-1:0] r_mod,
    output logic [NBITS-1:0] r2_mod,
    output logic [WBITS-1:0] n0_inv
);
    localparam int CW = $clog2(NBITS);
    state_t state, state_nx;
    logic [NBITS-1:0] n_r, x, x_nx;
    logic [NBITS:0] x2;
    logic [CW-1:0] cnt;
    logic [WBITS-1:0] inv;
    logic mode_r, bad_r, bad, last, start, inv_valid;

    assign start = state == IDLE && go;
    assign bad   = !n[0] || n == NBITS'(1);
    assign last  = cnt == CW'(NBITS - 1);
    assign busy  = state != IDLE;
    assign x2    = {x, 1'b0};
    assign x_nx  = NBITS'(x2 >= {1'b0, n_r} ? x2 - {1'b0, n_r} : x2);

    mont_ninv #(.WBITS(WBITS)) u_ninv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .n     (n[WBITS-1:0]),
        .result(inv),
        .valid (inv_valid)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state == IDLE ? (go ? (bad ? FIN : RED1) : IDLE)
                 : state == FIN  ? IDLE
                 : !last         ? state
                 : (state == RED1 && mode_r) ? RED2 : FIN;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            done   <= 1'b0;
            err    <= 1'b0;
            r_mod  <= '0;
            r2_mod <= '0;
            n0_inv <= '0;
            n_r    <= '0;
            x      <= '0;
            cnt    <= '0;
            mode_r <= 1'b0;
            bad_r  <= 1'b0;
        end else begin
            done <= state == FIN;
            if (start) begin
                n_r    <= n;
                mode_r <= mode;
                bad_r  <= bad;
                x      <= NBITS'(1);
                cnt    <= '0;
            end else if (state == RED1 || state == RED2) begin
                x   <= x_nx;
                cnt <= last ? '0 : cnt + CW'(1);
            end
            if (state == RED1 && last) r_mod <= x_nx;
            if (state == RED2 && last) r2_mod <= x_nx;
            if (state == FIN) begin
                err    <= bad_r;
                n0_inv <= (bad_r || !inv_valid) ? '0 : inv;
                if (bad_r) begin
                    r_mod  <= '0;
                    r2_mod <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_mont_precomp.sv
// tb_mont_precomp: scoreboard bench for an 8-bit and a 4096-bit mont_precomp instance
module tb_mont_precomp;
    typedef struct {
        logic       err;
        logic [7:0] r;
        logic [7:0] r2;
        logic [7:0] inv;
        int         go_cyc;
        int         lat;
    } exp8_t;
    typedef struct {
        logic [63:0] inv;
        int          go_cyc;
    } expb_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int compared = 0;
    int mismatched = 0;
    logic big_done = 1'b0;

    logic       rst_n, go, mode, busy, done, err;
    logic [7:0] n, r_mod, r2_mod, n0_inv;
    logic          rst_nb, gob, modeb, busyb, doneb, errb;
    logic [4095:0] nb, rb, r2b;
    logic [63:0]   invb;

    mont_precomp #(.NBITS(8), .WBITS(8)) dut (
        .clk(clk), .rst_n(rst_n), .go(go), .mode(mode), .n(n),
        .busy(busy), .done(done), .err(err),
        .r_mod(r_mod), .r2_mod(r2_mod), .n0_inv(n0_inv)
    );

    mont_precomp #(.NBITS(4096), .WBITS(64)) dut_big (
        .clk(clk), .rst_n(rst_nb), .go(gob), .mode(modeb), .n(nb),
        .busy(busyb), .done(doneb), .err(errb),
        .r_mod(rb), .r2_mod(r2b), .n0_inv(invb)
    );

    task automatic chk(input string name, input logic [4095:0] act, input logic [4095:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (low 64 bits)", name, act[63:0], exp[63:0]);
        end
    endtask

    exp8_t q8[$];
    expb_t qb[$];

    always @(negedge clk) begin
        exp8_t e;
        if (done) begin
            if (q8.size() == 0) chk("unexpected_done", done, 0);
            else begin
                e = q8.pop_front();
                chk("err", err, e.err);
                chk("r_mod", r_mod, e.r);
                chk("r2_mod", r2_mod, e.r2);
                chk("n0_inv", n0_inv, e.inv);
                chk("latency", 32'(cyc - e.go_cyc), 32'(e.lat));
            end
        end
    end

    always @(negedge clk) begin
        expb_t e;
        if (doneb) begin
            if (qb.size() == 0) chk("big_unexpected_done", doneb, 0);
            else begin
                e = qb.pop_front();
                chk("big_err", errb, 0);
                chk("big_r_mod", rb, 4096'(9));
                chk("big_r2_mod", r2b, 4096'(4));
                chk("big_n0_inv", invb, e.inv);
                chk("big_inv_product", 64'(64'd77 * invb), {64{1'b1}});
                chk("big_latency", 32'(cyc - e.go_cyc), 32'(8193));
            end
        end
    end

    task automatic start8(input logic [7:0] nv, input logic m, input logic push,
                          input logic e_err, input logic [7:0] e_r, input logic [7:0] e_r2,
                          input logic [7:0] e_inv, input int lat);
        go = 1'b1;
        n = nv;
        mode = m;
        if (push) q8.push_back('{e_err, e_r, e_r2, e_inv, cyc + 1, lat});
        @(negedge clk);
        go = 1'b0;
        n = 8'($urandom);
        mode = 1'($urandom);
        chk("busy_after_go", busy, 1);
    endtask

    task automatic wait_done8(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) return;
        end
        chk("done_timeout", done, 1);
    endtask

    task automatic check_zero8(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_r_mod"}, r_mod, 0);
        chk({tag, "_r2_mod"}, r2_mod, 0);
        chk({tag, "_n0_inv"}, n0_inv, 0);
    endtask

    initial begin
        longint unsigned x;
        rst_nb = 1'b0;
        gob = 1'b0;
        modeb = 1'b0;
        nb = '0;
        x = 64'd77;
        repeat (6) x = x * (64'd2 - 64'd77 * x);
        repeat (2) @(negedge clk);
        rst_nb = 1'b1;
        @(negedge clk);
        gob = 1'b1;
        modeb = 1'b1;
        nb = 4096'(77);
        qb.push_back('{~x + 64'd1, cyc + 1});
        @(negedge clk);
        gob = 1'b0;
        nb = '1;
        begin
            int i;
            for (i = 0; i < 9000 && !doneb; i++) @(negedge clk);
            if (!doneb) chk("big_done_timeout", doneb, 1);
        end
        @(negedge clk);
        big_done = 1'b1;
    end

    initial begin
        rst_n = 1'b0;
        go = 1'b0;
        mode = 1'b0;
        n = '0;
        repeat (2) @(negedge clk);
        check_zero8("reset");
        rst_n = 1'b1;
        @(negedge clk);
        start8(8'd77, 1'b1, 1'b1, 1'b0, 8'd25, 8'd9, 8'd123, 17);
        wait_done8(40);
        start8(8'd77, 1'b0, 1'b1, 1'b0, 8'd25, 8'd9, 8'd123, 9);
        wait_done8(40);
        start8(8'd76, 1'b1, 1'b1, 1'b1, 8'd0, 8'd0, 8'd0, 1);
        wait_done8(40);
        start8(8'd1, 1'b0, 1'b1, 1'b1, 8'd0, 8'd0, 8'd0, 1);
        wait_done8(40);
        start8(8'd77, 1'b0, 1'b1, 1'b0, 8'd25, 8'd0, 8'd123, 9);
        wait_done8(40);
        start8(8'd3, 1'b1, 1'b1, 1'b0, 8'd1, 8'd1, 8'd85, 17);
        wait_done8(40);
        start8(8'd255, 1'b1, 1'b1, 1'b0, 8'd1, 8'd1, 8'd1, 17);
        wait_done8(40);
        start8(8'd77, 1'b1, 1'b1, 1'b0, 8'd25, 8'd9, 8'd123, 17);
        repeat (4) @(negedge clk);
        go = 1'b1;
        n = 8'd13;
        mode = 1'b0;
        @(negedge clk);
        go = 1'b0;
        wait_done8(40);
        @(negedge clk);
        start8(8'd77, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_zero8("midrun_reset");
        rst_n = 1'b1;
        start8(8'd77, 1'b1, 1'b1, 1'b0, 8'd25, 8'd9, 8'd123, 17);
        wait_done8(40);
        repeat (3) @(negedge clk);
        begin
            int i;
            for (i = 0; i < 10000 && !big_done; i++) @(negedge clk);
            if (!big_done) chk("big_run_timeout", big_done, 1);
        end
        chk("small_queue_empty", 32'(q8.size()), 0);
        chk("big_queue_empty", 32'(qb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
